// File: rtl/glitch_free_clock_multiplexer.sv
// Glitch-free 2:1 clock multiplexer.
// A control FSM on `clock` drives one enable request per source. Each request
// passes through an ICG-style latch that is transparent only while its source
// is low, so a gate can never cut a high phase short. The latch outputs are
// synchronized back to `clock` as acknowledges. The FSM closes the old gate and
// waits for its acknowledge before it opens the new one (break-before-make).
//
// Request/acknowledge handshake (four-phase, per source N):
//   en_req_N rises  -> wait until ack_N = 1 (gate N is open)
//   en_req_N falls  -> wait until ack_N = 0 (gate N is closed)
// A new request is raised only after the previous one has been acknowledged
// low, so at most one gate is ever open.
module glitch_free_clock_multiplexer #(
   parameter int STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic clock_0,
   input  logic clock_1,
   input  logic select,
   output logic clock_out
);

   // Synchronizers shorter than two flops are not safe; clamp to two.
   localparam int N = (STAGES < 2) ? 2 : STAGES;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ENABLE_0  = 3'd1,
      ACTIVE_0  = 3'd2,
      DISABLE_0 = 3'd3,
      ENABLE_1  = 3'd4,
      ACTIVE_1  = 3'd5,
      DISABLE_1 = 3'd6
   } state_t;

   state_t       state;
   state_t       state_next;

   logic [N-1:0] sel_sync;
   logic [N-1:0] ack_0_sync;
   logic [N-1:0] ack_1_sync;
   logic         select_s;
   logic         ack_0;
   logic         ack_1;

   logic         en_req_0;
   logic         en_req_1;
   logic         en_lat_0;
   logic         en_lat_1;

   assign select_s = sel_sync[N-1];
   assign ack_0    = ack_0_sync[N-1];
   assign ack_1    = ack_1_sync[N-1];

   // Bring the asynchronous select and both latch states into the clock domain.
   always_ff @(posedge clock) begin
      if (reset) begin
         sel_sync   <= '0;
         ack_0_sync <= '0;
         ack_1_sync <= '0;
      end else begin
         sel_sync   <= {sel_sync[N-2:0], select};
         ack_0_sync <= {ack_0_sync[N-2:0], en_lat_0};
         ack_1_sync <= {ack_1_sync[N-2:0], en_lat_1};
      end
   end

   // State register; requests are registered from the next state so the
   // latch D inputs never carry decode glitches.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         en_req_0 <= 1'b0;
         en_req_1 <= 1'b0;
      end else begin
         state    <= state_next;
         en_req_0 <= (state_next == ENABLE_0) || (state_next == ACTIVE_0);
         en_req_1 <= (state_next == ENABLE_1) || (state_next == ACTIVE_1);
      end
   end

   // Next-state logic: select is only re-evaluated in IDLE and ACTIVE states,
   // so any switch that has started always completes.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:      state_next = select_s ? ENABLE_1 : ENABLE_0;
         ENABLE_0:  if (ack_0)     state_next = ACTIVE_0;
         ACTIVE_0:  if (select_s)  state_next = DISABLE_0;
         DISABLE_0: if (!ack_0)    state_next = ENABLE_1;
         ENABLE_1:  if (ack_1)     state_next = ACTIVE_1;
         ACTIVE_1:  if (!select_s) state_next = DISABLE_1;
         DISABLE_1: if (!ack_1)    state_next = ENABLE_0;
         default:   state_next = IDLE;
      endcase
   end

   // Gate latch for source 0: follows its request only while clock_0 is low.
   always_latch begin
      if (!clock_0) en_lat_0 <= en_req_0;
   end

   // Gate latch for source 1: follows its request only while clock_1 is low.
   always_latch begin
      if (!clock_1) en_lat_1 <= en_req_1;
   end

   assign clock_out = (clock_0 & en_lat_0) | (clock_1 & en_lat_1);

endmodule

// File: tb/tb_glitch_free_clock_multiplexer.sv
// Self-checking bench for glitch_free_clock_multiplexer.
// The reference model is expressed as timing rules on clock_out: in steady
// state the period equals the selected source period, every high pulse is
// half of one source period, and every low phase is at least half the
// shorter source period.
`timescale 1ns/1ps
module tb_glitch_free_clock_multiplexer;

   localparam int  STAGES = 2;
   localparam real T0     = 10.0;
   localparam real T1     = 20.0;

   logic clock   = 1'b0;
   logic reset   = 1'b1;
   logic clock_0 = 1'b0;
   logic clock_1 = 1'b0;
   logic select  = 1'b0;
   logic clock_out;
   bit   hold0   = 1'b0;

   int vectors     = 0;
   int miscompares = 0;

   real     hi_q[$];
   real     lo_q[$];
   real     per_q[$];
   realtime last_rise = -1.0;
   realtime last_fall = -1.0;

   glitch_free_clock_multiplexer #(.STAGES(STAGES)) dut (
      .clock     (clock),
      .reset     (reset),
      .clock_0   (clock_0),
      .clock_1   (clock_1),
      .select    (select),
      .clock_out (clock_out)
   );

   // Clock/reset block: control clock 2.5 ns, offset so its edges never
   // coincide with source edges; clock_0 can be frozen via hold0.
   initial begin
      #0.3;
      forever #1.25 clock = ~clock;
   end
   initial forever begin
      #5;
      if (!hold0) clock_0 = ~clock_0;
   end
   initial forever #10 clock_1 = ~clock_1;

   // Edge monitor: records periods, high widths and low widths of clock_out.
   always @(posedge clock_out) begin
      if (last_rise >= 0.0) per_q.push_back($realtime - last_rise);
      if (last_fall >= 0.0) lo_q.push_back($realtime - last_fall);
      last_rise = $realtime;
   end
   always @(negedge clock_out) begin
      if (last_rise >= 0.0) hi_q.push_back($realtime - last_rise);
      last_fall = $realtime;
   end

   // Reference model: steady-state period for a given select value.
   function automatic real exp_period(input logic sel);
      return sel ? T1 : T0;
   endfunction

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_near(input string tag, input real obs, input real exp);
      logic in_tol;
      in_tol = (obs >= exp * 0.95) && (obs <= exp * 1.05);
      vectors++;
      assert (in_tol === 1'b1)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0.3f ns, expected %0.3f ns +/-5 pct", tag, obs, exp);
      end
   endtask

   task automatic check_pulse(input string tag, input real obs);
      logic ok;
      ok = ((obs >= T0 / 2.0 * 0.95) && (obs <= T0 / 2.0 * 1.05)) ||
           ((obs >= T1 / 2.0 * 0.95) && (obs <= T1 / 2.0 * 1.05));
      vectors++;
      assert (ok === 1'b1)
      else begin
         miscompares++;
         $error("FAIL %s: high pulse %0.3f ns, expected 5 or 10 ns +/-5 pct", tag, obs);
      end
   endtask

   task automatic check_min(input string tag, input real obs, input real lim);
      logic ok;
      ok = (obs >= lim);
      vectors++;
      assert (ok === 1'b1)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0.3f ns, expected >= %0.3f ns", tag, obs, lim);
      end
   endtask

   task automatic clear_q();
      hi_q.delete();
      lo_q.delete();
      per_q.delete();
   endtask

   // Bounded wait for clock_out to reach a level; a timeout is a miscompare.
   task automatic wait_level(input string tag, input logic lvl);
      int n;
      n = 0;
      while ((clock_out !== lvl) && (n < 1000)) begin
         #0.1;
         n++;
      end
      check_bit(tag, clock_out, lvl);
   endtask

   // Measure a 100 ns steady window and compare against the model.
   task automatic measure_steady(input string tag, input logic sel);
      real t;
      t = exp_period(sel);
      clear_q();
      #100;
      check_bit({tag, "_running"}, (per_q.size() >= 4), 1'b1);
      foreach (per_q[i]) check_near({tag, "_period"}, per_q[i], t);
      foreach (hi_q[i])  check_near({tag, "_high"}, hi_q[i], t / 2.0);
   endtask

   task automatic check_no_glitch(input string tag);
      foreach (hi_q[i]) check_pulse({tag, "_pulse"}, hi_q[i]);
      foreach (lo_q[i]) check_min({tag, "_low"}, lo_q[i], 0.95 * T0 / 2.0);
   endtask

   // Directed step sequence.
   initial begin
      // Reset: output must settle low and stay low.
      reset  = 1'b1;
      select = 1'b0;
      #60;
      for (int i = 0; i < 8; i++) begin
         #4.7;
         check_bit("reset_low", clock_out, 1'b0);
      end

      // Release with select=0: 100 MHz.
      reset = 1'b0;
      #200;
      measure_steady("sel0", 1'b0);

      // 11 toggles with settle time; output alternates 50/100 MHz.
      for (int i = 0; i < 11; i++) begin
         select = ~select;
         #120;
         measure_steady("toggle", select);
      end

      // Reset while a clock_1 pulse is high: pulse completes, then stays low.
      select = 1'b1;
      #150;
      wait_level("rst_wait_low", 1'b0);
      wait_level("rst_wait_high", 1'b1);
      #2;
      reset = 1'b1;
      wait_level("rst_pulse_end", 1'b0);
      check_near("rst_pulse_width", last_fall - last_rise, T1 / 2.0);
      for (int i = 0; i < 10; i++) begin
         #9.7;
         check_bit("rst_hold_low", clock_out, 1'b0);
      end
      reset = 1'b0;
      #200;
      measure_steady("post_reset", 1'b1);

      // Double toggle inside the synchronizer window while in ACTIVE_0.
      select = 1'b0;
      #150;
      clear_q();
      select = 1'b1;
      #5;
      select = 1'b0;
      #300;
      check_no_glitch("double");
      measure_steady("double_end", 1'b0);

      // 100 random toggles at 0..600 ns intervals.
      clear_q();
      for (int i = 0; i < 100; i++) begin
         #($urandom_range(0, 600));
         select = ~select;
      end
      #200;
      check_no_glitch("random");
      measure_steady("random_end", select);

      // clock_0 frozen high: switch to 1 stalls with clock_out high.
      select = 1'b0;
      #200;
      @(posedge clock_0);
      #1;
      hold0  = 1'b1;
      select = 1'b1;
      clear_q();
      #100;
      for (int i = 0; i < 10; i++) begin
         #9.7;
         check_bit("stall_high", clock_out, 1'b1);
      end
      check_bit("stall_no_fall", (hi_q.size() == 0), 1'b1);
      hold0 = 1'b0;
      #200;
      measure_steady("stall_release", 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
